full_adder_signed_16bit: RTL and testbench
==========================================

Name: full_adder_signed_16bit

Overview:
Registered 16-bit two's-complement adder with carry-in, carry-out and signed-overflow flag. It is the add/subtract datapath element of the ALU; subtract is done upstream by feeding ~B with Cin=1. Operands are sampled on the clock edge and the result is presented one cycle later.

Parameters:
None. Width is fixed at 16 bits.

Ports:
clk       input   1   system clock, all state on rising edge
rst       input   1   synchronous, active-high reset
in_valid  input   1   A/B/Cin qualify this cycle
A         input   16  operand A, two's complement
B         input   16  operand B, two's complement
Cin       input   1   carry into bit 0
S         output  16  registered sum, A+B+Cin mod 2^16
Cout      output  1   registered carry out of bit 15 (unsigned carry)
Overflow  output  1   registered signed overflow flag
out_valid output  1   S/Cout/Overflow hold a result from the previous cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Arithmetic is a 17-bit unsigned add: {Cout,S} = A + B + Cin.
- Carry chain:
  - Structured as a ripple-carry chain of 16 one-bit full-adder cells.
  - Per cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = Cin.
- Cout = c_16.
- Overflow = c_15 XOR c_16. This is equivalent to: A[15]==B[15] and S[15]!=A[15].
- Latency: exactly 1 cycle.
  - On a rising edge with rst=0 and in_valid=1, S/Cout/Overflow load the new result and out_valid goes to 1.
- in_valid=0 at an edge (rst=0):
  - S/Cout/Overflow hold their previous values.
  - out_valid goes to 0.
- Back-to-back valid inputs give one result per cycle. There is no backpressure and no stall.
- Reset:
  - At a rising edge with rst=1: S=16'h0000, Cout=0, Overflow=0, out_valid=0.
  - rst has priority over in_valid. An operand presented in the same cycle as rst is discarded.
  - Asserting rst mid-stream drops the in-flight result. The first valid output after reset comes one cycle after the first in_valid sampled with rst=0.
- No combinational path from inputs to outputs.
- Wrap-around: results wrap modulo 2^16. Cout and Overflow are independent flags, and both may be 1 at once (e.g. neg+neg giving a positive sum).
- Inputs X/Z are not handled. Outputs are defined only from valid, known inputs.

Test Plan:
- Reset, then zeros, then small values:
  - rst=1 for 2 cycles -> S=0000, Cout=0, Overflow=0, out_valid=0.
  - A=0000, B=0000, Cin=0 -> S=0000, Cout=0, Overflow=0.
  - A=0001, B=0001, Cin=0 -> S=0002, Cout=0, Overflow=0. Result appears exactly one cycle after in_valid.
- Negative overflow and mixed-sign add:
  - A=8030, B=80E0, Cin=0 -> S=0110, Cout=1, Overflow=1.
  - A=8000, B=0400, Cin=0 -> S=8400, Cout=0, Overflow=0.
- Positive overflow:
  - A=4001, B=4003, Cin=0 -> S=8004, Cout=0, Overflow=1.
  - A=7FFF, B=0001, Cin=0 -> S=8000, Cout=0, Overflow=1.
- Unsigned wrap and carry-in:
  - A=FFFF, B=0001, Cin=0 -> S=0000, Cout=1, Overflow=0.
  - A=7FFE, B=0000, Cin=1 -> S=7FFF, Cout=0, Overflow=0.
  - Subtract form: A=0005, B=~0007=FFF8, Cin=1 -> S=FFFE, Cout=0, Overflow=0.
- Streaming, hold and reset:
  - Valid inputs on 3 consecutive cycles -> 3 consecutive correct results with out_valid=1.
  - Then in_valid=0 -> outputs hold, out_valid=0.
  - Assert rst in the same cycle as in_valid=1 -> next cycle S=0000, Cout=0, Overflow=0, out_valid=0.
- Randomized: 10k random A/B/Cin checked against a 17-bit reference sum and the sign-rule overflow.

Source files
------------

// File: rtl/full_adder_signed_16bit.sv
// Registered 16-bit two's-complement adder: {Cout,S} = A + B + Cin, plus signed overflow flag.
// Latency: exactly one cycle from an in_valid sample to out_valid and the registered result.
// No backpressure: one result per valid input cycle, never stalls; idle cycles hold the last result.
module full_adder_signed_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout,
  output logic        Overflow,
  output logic        out_valid
);

  localparam int W = 16;

  // Ripple-chain signals: carry[i] is the carry into cell i, carry[W] is the carry out.
  logic [W:0]   carry;
  logic [W-1:0] sum;
  logic         cout_c;
  logic         ovf_c;

  // Registered outputs and their next-state values.
  logic [W-1:0] s_q,    s_d;
  logic         cout_q, cout_d;
  logic         ovf_q,  ovf_d;
  logic         vld_q,  vld_d;

  // Ripple-carry chain of one-bit full-adder cells, bit 0 fed by Cin.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < W; i++) begin
      sum[i]     = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
    cout_c = carry[W];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    ovf_c  = carry[W-1] ^ carry[W];
  end

  // Next-state: load on a valid input, otherwise hold the last result; out_valid tracks in_valid.
  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = cout_c;
      ovf_d  = ovf_c;
    end
  end

  // Output registers; reset wins over a same-cycle valid operand, which is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_signed_16bit.sv
// Bench for full_adder_signed_16bit: directed vectors, hold/reset behaviour, then random traffic.
// Expected results are queued at issue time and matched by an independent output monitor.
// The DUT has no backpressure, so every valid input must produce exactly one output.
module tb_full_adder_signed_16bit;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic [15:0] S;
  logic        Cout;
  logic        Overflow;
  logic        out_valid;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  exp_t last_exp = '0;

  full_adder_signed_16bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .Cin(Cin),
    .S(S), .Cout(Cout), .Overflow(Overflow), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: plain 17-bit arithmetic and the sign rule for overflow.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    exp_t e;
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b} + {16'b0, ci};
    e.s  = full[15:0];
    e.c  = full[16];
    e.o  = (a[15] == b[15]) && (full[15] != a[15]);
    return e;
  endfunction

  // One clock of stimulus; inputs change on the falling edge, outputs checked at the next one.
  task automatic cycle(input logic r, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input string tag);
    exp_t e;
    rst = r; in_valid = v; A = a; B = b; Cin = ci;
    if (r) begin
      last_exp = '0;
    end else if (v) begin
      e = model(a, b, ci);
      sb.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    total++;
    if (out_valid !== (v && !r)) begin
      bad++;
      $display("FAIL %s out_valid: got %b want %b", tag, out_valid, (v && !r));
    end
    if (r || !v) begin
      total++;
      if ({S, Cout, Overflow} !== {last_exp.s, last_exp.c, last_exp.o}) begin
        bad++;
        $display("FAIL %s %s: got S=%h C=%b V=%b want S=%h C=%b V=%b", tag,
                 r ? "reset_vals" : "hold", S, Cout, Overflow,
                 last_exp.s, last_exp.c, last_exp.o);
      end
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_output: got S=%h C=%b V=%b with nothing outstanding",
                   S, Cout, Overflow);
        end else begin
          e = sb.pop_front();
          if ({S, Cout, Overflow} !== {e.s, e.c, e.o}) begin
            bad++;
            $display("FAIL result: got S=%h C=%b V=%b want S=%h C=%b V=%b",
                     S, Cout, Overflow, e.s, e.c, e.o);
          end
        end
      end
    end
  end

  logic [15:0] va [10] = '{16'h0000, 16'h0001, 16'h8030, 16'h8000, 16'h4001,
                           16'h7FFF, 16'hFFFF, 16'h7FFE, 16'h0005, 16'h1234};
  logic [15:0] vb [10] = '{16'h0000, 16'h0001, 16'h80E0, 16'h0400, 16'h4003,
                           16'h0001, 16'h0001, 16'h0000, 16'hFFF8, 16'hEDCB};
  logic        vc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // Reset held for two cycles.
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "reset0");
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, "reset1");
    // Directed vectors, back to back (also the streaming case).
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, va[i], vb[i], vc[i], "directed");
    // Idle: outputs hold last result, out_valid drops.
    cycle(1'b0, 1'b0, 16'hAAAA, 16'h5555, 1'b1, "idle0");
    cycle(1'b0, 1'b0, 16'h0F0F, 16'hF0F0, 1'b0, "idle1");
    // Gap then single result, then reset coinciding with a valid operand.
    cycle(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, "single");
    cycle(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1, "rst_with_valid");
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "post_reset_idle");
    cycle(1'b0, 1'b1, 16'h0002, 16'h0003, 1'b0, "first_after_reset");
    // Random traffic with occasional idle cycles.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b0, ($urandom_range(0, 9) != 0), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), "random");
    end
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, "drain");
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL outstanding: got %0d results never presented, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
